// File: rtl/alu_seq.sv
// Sequential 16-op ALU with valid/ready handshakes, iterative MUL and DIV.
// Define ALU_DIV_EN to build the restoring divider; otherwise DIV returns 0 with err=1.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [3:0]           cmd,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   d_out,
    output logic                 err
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam int RW    = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic [3:0] {
        OP_ADD, OP_INC, OP_SUB, OP_DEC, OP_MUL, OP_DIV, OP_SHL, OP_SHR,
        OP_AND, OP_OR, OP_INV, OP_NAND, OP_NOR, OP_XOR, OP_XNOR, OP_BUF
    } op_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RW-1:0]    opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [RW-1:0]    acc_q, acc_d;
    logic [RW-1:0]    d_out_q, d_out_d;
    logic             err_q, err_d;
`ifdef ALU_DIV_EN
    logic             is_div_q, is_div_d;
    logic [WIDTH:0]   rem_sh, rem_nx;
    logic             q_bit;
`endif
    logic [RW-1:0]    ax, bx, quick_res, mul_acc, iter_res;
    op_t              op;

    assign ax = {{WIDTH{1'b0}}, a};
    assign bx = {{WIDTH{1'b0}}, b};
    assign op = op_t'(cmd);

    always_comb begin
        quick_res = '0;
        case (op)
            OP_ADD:  quick_res = ax + bx;
            OP_INC:  quick_res = ax + RW'(1);
            OP_SUB:  quick_res = ax - bx;
            OP_DEC:  quick_res = ax - RW'(1);
            OP_SHL:  quick_res = ax << b;
            OP_SHR:  quick_res = ax >> b;
            OP_AND:  quick_res = {{WIDTH{1'b0}}, a & b};
            OP_OR:   quick_res = {{WIDTH{1'b0}}, a | b};
            OP_INV:  quick_res = {{WIDTH{1'b0}}, ~a};
            OP_NAND: quick_res = {{WIDTH{1'b0}}, ~(a & b)};
            OP_NOR:  quick_res = {{WIDTH{1'b0}}, ~(a | b)};
            OP_XOR:  quick_res = {{WIDTH{1'b0}}, a ^ b};
            OP_XNOR: quick_res = {{WIDTH{1'b0}}, ~(a ^ b)};
            OP_BUF:  quick_res = ax;
            default: quick_res = '0;
        endcase
    end

    // One iteration step. For DIV, acc holds the partial remainder and the low
    // half of opa shifts dividend bits out while quotient bits shift in.
    always_comb begin
        mul_acc  = opb_q[0] ? acc_q + opa_q : acc_q;
        iter_res = mul_acc;
`ifdef ALU_DIV_EN
        rem_sh = {acc_q[WIDTH-1:0], opa_q[WIDTH-1]};
        q_bit  = (rem_sh >= {1'b0, opb_q});
        rem_nx = q_bit ? rem_sh - {1'b0, opb_q} : rem_sh;
        if (is_div_q) begin
            iter_res = {rem_nx[WIDTH-1:0], opa_q[WIDTH-2:0], q_bit};
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        acc_d   = acc_q;
        d_out_d = d_out_q;
        err_d   = err_q;
`ifdef ALU_DIV_EN
        is_div_d = is_div_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    opa_d = ax;
                    opb_d = b;
                    acc_d = '0;
                    if (op == OP_MUL) begin
                        state_d = BUSY;
                        cnt_d   = CNT_W'(WIDTH);
`ifdef ALU_DIV_EN
                        is_div_d = 1'b0;
                    end else if (op == OP_DIV) begin
                        state_d  = BUSY;
                        cnt_d    = CNT_W'(WIDTH);
                        is_div_d = 1'b1;
`endif
                    end else begin
                        d_out_d = quick_res;
`ifdef ALU_DIV_EN
                        err_d   = 1'b0;
`else
                        err_d   = (op == OP_DIV);
`endif
                        state_d = DONE;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                acc_d = mul_acc;
                opa_d = opa_q << 1;
                opb_d = opb_q >> 1;
`ifdef ALU_DIV_EN
                if (is_div_q) begin
                    acc_d = {{(RW-WIDTH-1){1'b0}}, rem_nx};
                    opa_d = {{WIDTH{1'b0}}, opa_q[WIDTH-2:0], q_bit};
                    opb_d = opb_q;
                end
`endif
                if (cnt_q == CNT_W'(1)) begin
                    d_out_d = iter_res;
`ifdef ALU_DIV_EN
                    err_d   = is_div_q && (opb_q == '0);
`else
                    err_d   = 1'b0;
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            d_out_q  <= '0;
            err_q    <= 1'b0;
`ifdef ALU_DIV_EN
            is_div_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            d_out_q  <= d_out_d;
            err_q    <= err_d;
`ifdef ALU_DIV_EN
            is_div_q <= is_div_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign d_out     = d_out_q;
    assign err       = err_q;

endmodule
